// File: rtl/dvtb_test_pkg.sv
// dvtb_test_pkg: shared FSM states, verdict record and width helper for the end-of-test monitor
package dvtb_test_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} dvtb_test_state_e;
  typedef struct packed {logic pass; logic fail; logic timeout; logic stall;} dvtb_verdict_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dvtb_test_monitor_if.sv
// dvtb_test_monitor_if: channel stimulus from the bench and verdict/status back from the monitor
interface dvtb_test_monitor_if #(parameter int N_CH = 4, parameter int CNT_W = 64, parameter int IDX_W = 2);
  import dvtb_test_pkg::*;
  logic start;
  logic [N_CH-1:0] ch_enable;
  logic [N_CH-1:0] test_end;
  logic [N_CH-1:0] test_fail;
  logic activity;
  dvtb_test_state_e state;
  logic done;
  logic pass;
  logic fail;
  logic timeout;
  logic stall;
  logic [N_CH-1:0] fail_mask;
  logic [IDX_W-1:0] first_fail_idx;
  logic [CNT_W-1:0] cycles;
  logic finish_req;
  modport master(output start, ch_enable, test_end, test_fail, activity,
                 input state, done, pass, fail, timeout, stall, fail_mask, first_fail_idx, cycles, finish_req);
  modport slave(input start, ch_enable, test_end, test_fail, activity,
                output state, done, pass, fail, timeout, stall, fail_mask, first_fail_idx, cycles, finish_req);
endinterface

// File: rtl/dvtb_sat_counter.sv
// dvtb_sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module dvtb_sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/dvtb_test_monitor.sv
// dvtb_test_monitor: sticky per-channel end/fail tracking, timeout/stall watchdogs, drain window and verdict
module dvtb_test_monitor import dvtb_test_pkg::*; #(
  parameter int N_CH         = 4,
  parameter int END_ANY      = 0,
  parameter int TIMEOUT      = 0,
  parameter int STALL_LIMIT  = 0,
  parameter int DRAIN_CYCLES = 200,
  parameter int CNT_W        = 64,
  parameter int IDX_W        = idx_w(N_CH)
) (
  input logic clk,
  input logic rstn,
  dvtb_test_monitor_if.slave mon
);
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  dvtb_test_state_e st, st_nxt;
  dvtb_verdict_t vd;
  logic [N_CH-1:0] end_latch, fmask, new_fail, fail_nxt;
  logic [CNT_W-1:0] to_cnt, st_cnt;
  logic [DW-1:0] dr_cnt;
  logic [IDX_W-1:0] ffi;
  logic in_run, sampling, end_cond, to_hit, st_hit, drain_done, fin, any_fail;
  function automatic logic [IDX_W-1:0] lowest(input logic [N_CH-1:0] v);
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (v[i]) lowest = IDX_W'(i);
  endfunction
  assign in_run     = st == ST_RUN;
  assign sampling   = in_run || st == ST_DRAIN;
  assign new_fail   = sampling ? mon.test_fail & mon.ch_enable & ~fmask : '0;
  assign fail_nxt   = fmask | new_fail;
  assign end_cond   = END_ANY != 0 ? |end_latch : (|mon.ch_enable && &(end_latch | ~mon.ch_enable));
  assign to_hit     = in_run && TIMEOUT != 0 && to_cnt == CNT_W'(TIMEOUT - 1);
  assign st_hit     = in_run && STALL_LIMIT != 0 && !mon.activity && st_cnt == CNT_W'(STALL_LIMIT - 1);
  assign drain_done = st == ST_DRAIN && dr_cnt == DW'(DRAIN_CYCLES - 1);
  // a fail sampled on the last DRAIN cycle still lands in the verdict
  assign any_fail   = |fail_nxt || vd.timeout || vd.stall;
  dvtb_sat_counter #(CNT_W) u_cyc (.clk, .rstn, .clr(1'b0), .inc(sampling), .q(mon.cycles));
  dvtb_sat_counter #(CNT_W) u_to (.clk, .rstn, .clr(1'b0), .inc(in_run), .q(to_cnt));
  dvtb_sat_counter #(CNT_W) u_st (.clk, .rstn, .clr(mon.activity), .inc(in_run), .q(st_cnt));
  dvtb_sat_counter #(DW) u_dr (.clk, .rstn, .clr(st != ST_DRAIN), .inc(1'b1), .q(dr_cnt));
  always_comb begin
    st_nxt = (st == ST_IDLE && mon.start) ? ST_RUN :
             (in_run && (end_cond || to_hit || st_hit)) ? ST_DRAIN :
             drain_done ? ST_DONE : st;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st        <= ST_IDLE;
      vd        <= '0;
      end_latch <= '0;
      fmask     <= '0;
      ffi       <= '0;
      fin       <= 1'b0;
    end else begin
      st    <= st_nxt;
      fmask <= fail_nxt;
      fin   <= drain_done;
      if (sampling) end_latch <= end_latch | (mon.test_end & mon.ch_enable);
      if (fmask == '0 && new_fail != '0) ffi <= lowest(new_fail);
      if (to_hit) vd.timeout <= 1'b1;
      if (st_hit) vd.stall <= 1'b1;
      if (drain_done) begin
        vd.fail <= any_fail;
        vd.pass <= !any_fail;
      end
    end
  assign mon.state          = st;
  assign mon.done           = st == ST_DONE;
  assign mon.pass           = vd.pass;
  assign mon.fail           = vd.fail;
  assign mon.timeout        = vd.timeout;
  assign mon.stall          = vd.stall;
  assign mon.fail_mask      = fmask;
  assign mon.first_fail_idx = ffi;
  assign mon.finish_req     = fin;
endmodule

// File: tb/tb_dvtb_test_monitor.sv
// tb_dvtb_test_monitor: two monitor configurations driven by shared stimulus, checked against a cycle model
module tb_dvtb_test_monitor;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic act = 1'b1;
  logic [3:0] en = 4'hF;
  logic [3:0] te = '0;
  logic [3:0] tf = '0;
  always #5 clk = ~clk;
  dvtb_test_monitor_if #(.N_CH(4), .CNT_W(6), .IDX_W(2)) if0 ();
  dvtb_test_monitor_if #(.N_CH(4), .CNT_W(8), .IDX_W(2)) if1 ();
  assign if0.start = start;
  assign if0.ch_enable = en;
  assign if0.test_end = te;
  assign if0.test_fail = tf;
  assign if0.activity = act;
  assign if1.start = start;
  assign if1.ch_enable = en;
  assign if1.test_end = te;
  assign if1.test_fail = tf;
  assign if1.activity = act;
  dvtb_test_monitor #(.N_CH(4), .END_ANY(0), .TIMEOUT(60), .STALL_LIMIT(8), .DRAIN_CYCLES(5), .CNT_W(6))
    u0 (.clk(clk), .rstn(rstn), .mon(if0));
  dvtb_test_monitor #(.N_CH(4), .END_ANY(1), .TIMEOUT(100), .STALL_LIMIT(0), .DRAIN_CYCLES(4), .CNT_W(8))
    u1 (.clk(clk), .rstn(rstn), .mon(if1));
  localparam int M_EA [2] = '{0, 1};
  localparam int M_TO [2] = '{60, 100};
  localparam int M_SL [2] = '{8, 0};
  localparam int M_DR [2] = '{5, 4};
  localparam int M_MAX [2] = '{63, 255};
  // model phase: 0 idle, 1 run, 2 drain, 3 done
  int ph [2], cyc [2], runc [2], quiet [2], dcnt [2], ffi [2];
  logic [3:0] endl [2], fm [2];
  bit tmo [2], stl [2], pas [2], fal [2], fin [2];
  int n_chk = 0;
  int n_err = 0;
  int s0, fl;
  int end_at [4], fail_at [4];
  bit reset_hit;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; cyc[k] = 0; runc[k] = 0; quiet[k] = 0; dcnt[k] = 0; ffi[k] = 0;
      endl[k] = '0; fm[k] = '0; tmo[k] = 0; stl[k] = 0; pas[k] = 0; fal[k] = 0; fin[k] = 0;
    end
  endtask
  task automatic model_step(input int k);
    int p;
    logic [3:0] nf;
    bit ec, th, sh;
    p = ph[k];
    fin[k] = 0;
    ec = M_EA[k] != 0 ? (endl[k] != 0) : (en != 0 && (endl[k] | ~en) == 4'hF);
    if (p == 1 || p == 2) begin
      if (cyc[k] < M_MAX[k]) cyc[k]++;
      nf = tf & en & ~fm[k];
      if (fm[k] == 0 && nf != 0)
        for (int i = 0; i < 4; i++) if (nf[i]) begin ffi[k] = i; break; end
      fm[k] |= nf;
      endl[k] |= te & en;
    end
    if (p == 0 && start) ph[k] = 1;
    if (p == 1) begin
      runc[k]++;
      quiet[k] = act ? 0 : quiet[k] + 1;
      th = M_TO[k] != 0 && runc[k] == M_TO[k];
      sh = M_SL[k] != 0 && quiet[k] == M_SL[k];
      if (th) tmo[k] = 1;
      if (sh) stl[k] = 1;
      if (ec || th || sh) begin ph[k] = 2; dcnt[k] = 0; end
    end
    if (p == 2) begin
      dcnt[k]++;
      if (dcnt[k] == M_DR[k]) begin
        ph[k] = 3; fin[k] = 1;
        fal[k] = fm[k] != 0 || tmo[k] || stl[k];
        pas[k] = !fal[k];
      end
    end
  endtask
  task automatic compare(input int k);
    string p;
    p = k != 0 ? "u1" : "u0";
    check({p, ".state"}, k != 0 ? 64'(if1.state) : 64'(if0.state), 64'(ph[k]));
    check({p, ".flags"},
          k != 0 ? 64'({if1.done, if1.pass, if1.fail, if1.timeout, if1.stall, if1.finish_req})
                 : 64'({if0.done, if0.pass, if0.fail, if0.timeout, if0.stall, if0.finish_req}),
          64'({ph[k] == 3, pas[k], fal[k], tmo[k], stl[k], fin[k]}));
    check({p, ".fail_mask"}, k != 0 ? 64'(if1.fail_mask) : 64'(if0.fail_mask), 64'(fm[k]));
    check({p, ".first_fail_idx"}, k != 0 ? 64'(if1.first_fail_idx) : 64'(if0.first_fail_idx), 64'(ffi[k]));
    check({p, ".cycles"}, k != 0 ? 64'(if1.cycles) : 64'(if0.cycles), 64'(cyc[k]));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; start = 0; te = '0; tf = '0; act = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare(0);
    compare(1);
    rstn = 1'b1;
  endtask
  initial begin
    model_reset();
    for (int sc = 0; sc < 16; sc++) begin
      do_reset();
      fl = sc < 7 ? sc : 7;
      s0 = $urandom_range(0, 3);
      en = 4'hF;
      reset_hit = 0;
      for (int i = 0; i < 4; i++) begin end_at[i] = -1; fail_at[i] = -1; end
      case (fl)
        0: for (int i = 0; i < 4; i++) end_at[i] = s0 + 10 * (i + 1);
        1: begin
          en = 4'b1101;
          fail_at[1] = s0 + 12; fail_at[3] = s0 + 12;
          for (int i = 0; i < 4; i++) end_at[i] = s0 + 30;
        end
        4: for (int i = 0; i < 4; i++) end_at[i] = s0 + 59;
        5: for (int i = 0; i < 4; i++) end_at[i] = s0 + 5;
        6: begin end_at[2] = s0 + 15; fail_at[3] = s0 + 19; end
        7: begin
          en = 4'($urandom_range(0, 15));
          for (int i = 0; i < 4; i++) begin
            end_at[i] = $urandom_range(0, 3) == 0 ? -1 : s0 + int'($urandom_range(2, 70));
            fail_at[i] = $urandom_range(0, 2) != 0 ? -1 : s0 + int'($urandom_range(2, 80));
          end
        end
        default: ;
      endcase
      for (int c = 0; c < 400; c++) begin
        start = c >= s0;
        for (int i = 0; i < 4; i++) begin
          te[i] = c == end_at[i];
          tf[i] = c == fail_at[i];
        end
        act = fl == 3 ? (c < s0 + 6 ? c[0] : c == s0 + 12)
            : fl == 7 ? $urandom_range(0, 9) != 0 : 1'b1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare(0);
        compare(1);
        if (fl == 5 && ph[0] == 2 && dcnt[0] == 2) begin
          #2 rstn = 1'b0;
          #1 model_reset();
          compare(0);
          compare(1);
          reset_hit = 1;
          break;
        end
        if (ph[0] == 3 && ph[1] == 3) break;
      end
      if (fl != 5) check("both_done", {if0.done, if1.done}, 2'b11);
      else check("drain_reset_seen", 64'(reset_hit), 64'(1));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
